// File: rtl/shift_sched_pkg.sv
// Shared constants and encodings for the shift_sched operand scheduler.
package shift_sched_pkg;

  localparam int unsigned LAT = 4;

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
  typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_e;
  typedef enum logic {OP_SHIFT = 1'b0, OP_ROT = 1'b1} rot_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner and
// moves only when a grant (and therefore a transfer) happens.
module rr_arb2
  import shift_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_id_e last_q, last_d;

  always_comb begin
    grant = '0;
    if (!rst) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_q == REQ_A) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant[0]) begin
      last_d = REQ_A;
    end else if (grant[1]) begin
      last_d = REQ_B;
    end
  end

  // Resetting to B makes A the first winner under contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Two-requester scheduler for an external LAT-cycle shifter with tag tracking.
// Optional per-requester accept counters: define SHIFT_SCHED_STATS_EN.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int unsigned LAT = shift_sched_pkg::LAT,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_x_a,
  input  logic [W-1:0] req_x_b,
  input  logic [4:0]   req_amt_a,
  input  logic [4:0]   req_amt_b,
  input  logic         req_dir_a,
  input  logic         req_dir_b,
  input  logic         req_rot_a,
  input  logic         req_rot_b,
  output logic [W-1:0] sh_x,
  output logic [4:0]   sh_r,
  output logic         sh_s,
  output logic         sh_rot,
  input  logic [W-1:0] sh_y,
  output logic [1:0]   rsp_valid,
  output logic [W-1:0] rsp_data,
`ifdef SHIFT_SCHED_STATS_EN
  output logic [2:0]   inflight,
  output logic [15:0]  stat_a,
  output logic [15:0]  stat_b
`else
  output logic [2:0]   inflight
`endif
);

  logic [1:0]     grant;
  logic           accept;
  logic           rsp_any;
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic [2:0]     inflight_q, inflight_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .grant (grant)
  );

  always_comb begin
    accept    = |grant;
    req_ready = grant;
    sh_x      = '0;
    sh_r      = '0;
    sh_s      = 1'b0;
    sh_rot    = 1'b0;
    if (grant[0]) begin
      sh_x   = req_x_a;
      sh_r   = req_amt_a;
      sh_s   = req_dir_a;
      sh_rot = req_rot_a;
    end else if (grant[1]) begin
      sh_x   = req_x_b;
      sh_r   = req_amt_b;
      sh_s   = req_dir_b;
      sh_rot = req_rot_b;
    end
  end

  // Tags travel alongside the shifter's own pipeline, one stage per cycle.
  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = accept;
    tag_id_d[0] = grant[1] ? REQ_B : REQ_A;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  always_comb begin
    rsp_any   = tag_v_q[LAT-1] & ~rst;
    rsp_valid = '0;
    if (rsp_any) begin
      rsp_valid = (tag_id_q[LAT-1] == REQ_B) ? 2'b10 : 2'b01;
    end
    rsp_data = rsp_any ? sh_y : '0;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, rsp_any})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
    inflight = rst ? '0 : inflight_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      inflight_q <= '0;
    end else begin
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef SHIFT_SCHED_STATS_EN
  logic [15:0] stat_a_q, stat_a_d;
  logic [15:0] stat_b_q, stat_b_d;

  always_comb begin
    stat_a_d = stat_a_q + {15'd0, grant[0]};
    stat_b_d = stat_b_q + {15'd0, grant[1]};
    stat_a   = stat_a_q;
    stat_b   = stat_b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched with a behavioural shifter and scheduler model.
module tb_shift_sched;

  localparam int L = 4;

  logic        clk, rst;
  logic [1:0]  req_valid, req_ready, rsp_valid;
  logic [31:0] req_x_a, req_x_b, sh_x, sh_y, rsp_data;
  logic [4:0]  req_amt_a, req_amt_b, sh_r;
  logic        req_dir_a, req_dir_b, req_rot_a, req_rot_b, sh_s, sh_rot;
  logic [2:0]  inflight;
`ifdef SHIFT_SCHED_STATS_EN
  logic [15:0] stat_a, stat_b;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  shift_sched #(.LAT(L), .W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x_a(req_x_a), .req_x_b(req_x_b), .req_amt_a(req_amt_a), .req_amt_b(req_amt_b),
    .req_dir_a(req_dir_a), .req_dir_b(req_dir_b), .req_rot_a(req_rot_a), .req_rot_b(req_rot_b),
    .sh_x(sh_x), .sh_r(sh_r), .sh_s(sh_s), .sh_rot(sh_rot), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef SHIFT_SCHED_STATS_EN
    .inflight(inflight), .stat_a(stat_a), .stat_b(stat_b)
`else
    .inflight(inflight)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] amt,
                                            input logic left, input logic rot);
    logic [63:0] d;
    if (rot) begin
      if (left) begin
        d = {x, x} << amt;
        return d[63:32];
      end
      d = {x, x} >> amt;
      return d[31:0];
    end
    return left ? (x << amt) : (x >> amt);
  endfunction

  // External shifter: fixed L-cycle pipeline, never cleared by reset.
  logic [31:0] shp [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) shp[i] <= shp[i-1];
    shp[0] <= ref_shift(sh_x, sh_r, sh_s, sh_rot);
  end
  assign sh_y = shp[L-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected results queue keyed by due cycle.
  typedef struct {int due; logic id; logic [31:0] data;} exp_t;
  exp_t        exp_q[$];
  logic        m_last = 1'b1;
  logic [1:0]  m_g;
  logic [15:0] m_stat_a = '0, m_stat_b = '0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_inflight", inflight, 3'd0);
      exp_q.delete();
      m_last = 1'b1;
      m_stat_a = '0;
      m_stat_b = '0;
    end else begin
      chk("mon_inflight", inflight, exp_q.size());
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("mon_rsp_valid", rsp_valid, exp_q[0].id ? 2'b10 : 2'b01);
        chk("mon_rsp_data", rsp_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        chk("mon_idle_valid", rsp_valid, 2'b00);
        chk("mon_idle_data", rsp_data, 32'h0);
      end
`ifdef SHIFT_SCHED_STATS_EN
      chk("mon_stat_a", stat_a, m_stat_a);
      chk("mon_stat_b", stat_b, m_stat_b);
`endif
      // Winner: the only valid requester, or the one that did not win last time.
      if (req_valid == 2'b11)      m_g = m_last ? 2'b01 : 2'b10;
      else                         m_g = req_valid;
      chk("mon_ready", req_ready, m_g);
      if (m_g == 2'b01) begin
        exp_q.push_back('{cyc + L, 1'b0, ref_shift(req_x_a, req_amt_a, req_dir_a, req_rot_a)});
        m_last = 1'b0;
        m_stat_a++;
      end else if (m_g == 2'b10) begin
        exp_q.push_back('{cyc + L, 1'b1, ref_shift(req_x_b, req_amt_b, req_dir_b, req_rot_b)});
        m_last = 1'b1;
        m_stat_b++;
      end
    end
  end

  typedef struct {
    logic [1:0] valid; logic [31:0] x; logic [4:0] amt; logic dir; logic rot; logic [31:0] exp_y;
  } vec_t;
  vec_t vec [10];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int acc, rcnt, first, last, seen;
  logic [2:0] maxinf;
  logic [1:0] held;

  initial begin
    vec[0] = '{2'b01, 32'h0000_00F0, 5'd4,  1'b1, 1'b0, 32'h0000_0F00};
    vec[1] = '{2'b10, 32'h8000_0001, 5'd1,  1'b0, 1'b1, 32'hC000_0000};
    vec[2] = '{2'b01, 32'h8000_0001, 5'd1,  1'b0, 1'b0, 32'h4000_0000};
    vec[3] = '{2'b10, 32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678};
    vec[4] = '{2'b01, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
    vec[5] = '{2'b10, 32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000};
    vec[6] = '{2'b01, 32'h0000_0003, 5'd31, 1'b1, 1'b1, 32'h8000_0001};
    vec[7] = '{2'b10, 32'hF000_000F, 5'd4,  1'b1, 1'b1, 32'h0000_00FF};
    vec[8] = '{2'b01, 32'hDEAD_BEEF, 5'd8,  1'b0, 1'b1, 32'hEFDE_ADBE};
    vec[9] = '{2'b10, 32'hFFFF_FFFF, 5'd16, 1'b0, 1'b0, 32'h0000_FFFF};

    rst = 1'b1; req_valid = '0;
    req_x_a = '0; req_x_b = '0; req_amt_a = '0; req_amt_b = '0;
    req_dir_a = 1'b0; req_dir_b = 1'b0; req_rot_a = 1'b0; req_rot_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single-issue vectors; the first one lands in the first cycle after reset.
    for (int i = 0; i < 10; i++) begin
      req_x_a = vec[i].x;     req_x_b = vec[i].x;
      req_amt_a = vec[i].amt; req_amt_b = vec[i].amt;
      req_dir_a = vec[i].dir; req_dir_b = vec[i].dir;
      req_rot_a = vec[i].rot; req_rot_b = vec[i].rot;
      req_valid = vec[i].valid;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), req_ready, vec[i].valid);
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (L - 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vec[i].valid);
      chk($sformatf("vec%0d_rsp_data", i), rsp_data, vec[i].exp_y);
      @(posedge clk); #1;
    end

    // Contention: A and B both valid for four cycles.
    do_reset();
    req_x_a = 32'h1; req_amt_a = 5'd1; req_dir_a = 1'b1; req_rot_a = 1'b0;
    req_x_b = 32'h1; req_amt_b = 5'd2; req_dir_b = 1'b1; req_rot_b = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr_rsp_valid%0d", i), rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr_rsp_data%0d", i), rsp_data, (i % 2 == 0) ? 32'h2 : 32'h4);
      @(posedge clk); #1;
    end

    // Reset while three operations are in flight.
    do_reset();
    req_x_a = 32'h55; req_amt_a = 5'd3; req_dir_a = 1'b1; req_rot_a = 1'b0;
    req_valid = 2'b01;
    repeat (3) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_gate", rsp_valid, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) chk("rstmid_inflight", inflight, 3'd0);
      if (rsp_valid != 2'b00) seen++;
      @(posedge clk); #1;
    end
    chk("rstmid_no_rsp", seen, 0);

    // Streaming: A valid for 20 consecutive cycles.
    do_reset();
    acc = 0; rcnt = 0; first = -1; last = -1; maxinf = '0;
    for (int k = 0; k < 28; k++) begin
      req_valid = (k < 20) ? 2'b01 : 2'b00;
      req_x_a = 32'(k) * 32'h0101_0101; req_amt_a = 5'(k); req_dir_a = k[0]; req_rot_a = k[1];
      @(negedge clk);
      if (req_ready == 2'b01) acc++;
      if (rsp_valid == 2'b01) begin
        rcnt++;
        if (first < 0) first = k;
        last = k;
      end
      if (inflight > maxinf) maxinf = inflight;
      @(posedge clk); #1;
    end
    chk("stream_accepts", acc, 20);
    chk("stream_rsp_count", rcnt, 20);
    chk("stream_first_rsp", first, L);
    chk("stream_contiguous", last - first + 1, 20);
    chk("stream_inflight_max", maxinf, 3'd4);
`ifdef SHIFT_SCHED_STATS_EN
    chk("stream_stat_a", stat_a, 16'd20);
`endif

    // Randomised traffic with operand hold while stalled and occasional reset.
    held = 2'b00;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!held[0]) begin
        req_valid[0] = ($urandom_range(0, 99) < 65);
        req_x_a = $urandom; req_amt_a = 5'($urandom); req_dir_a = 1'($urandom); req_rot_a = 1'($urandom);
      end
      if (!held[1]) begin
        req_valid[1] = ($urandom_range(0, 99) < 65);
        req_x_b = $urandom; req_amt_b = 5'($urandom); req_dir_b = 1'($urandom); req_rot_b = 1'($urandom);
      end
      @(negedge clk);
      held = req_valid & ~req_ready;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    req_valid = 2'b00;
    repeat (L + 3) @(posedge clk);
    @(negedge clk);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter LAT, default 4, shifter pipeline latency in cycles from operand presentation to valid result.
REQ-002 Parameter W, default 32, operand/result width; fixed at 32 for the current shifter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid (bit0 = requester A, bit1 = requester B).
REQ-006 req_ready  output  2  per-requester accept (one-hot or zero); transfer occurs when valid and ready are both high.
REQ-007 req_x_a / req_x_b  input  W  operand per requester.
REQ-008 req_amt_a / req_amt_b  input  5  shift/rotate amount per requester.
REQ-009 req_dir_a / req_dir_b  input  1  1 = left, 0 = right.
REQ-010 req_rot_a / req_rot_b  input  1  0 = shift, 1 = rotate.
REQ-011 sh_x  output  W, sh_r  output  5, sh_s  output  1, sh_rot  output  1  operands driven to the shifter.
REQ-012 sh_y  input  W  shifter result.
REQ-013 rsp_valid  output  2  one-cycle per-requester result valid; no backpressure.
REQ-014 rsp_data  output  W  result; equals sh_y whenever any rsp_valid bit is high.
REQ-015 inflight  output  3  count of accepted operations not yet returned (0..LAT).

Function
REQ-016 At most one request SHALL be accepted per cycle; sh_* SHALL be driven combinationally from the granted requester, and held at zero when there is no grant.
REQ-017 Arbitration SHALL be round-robin: when both are valid, grant goes to the requester not granted most recently; with only one valid, it is granted immediately.
REQ-018 The last-granted pointer SHALL update only on an accepted transfer.
REQ-019 A requester SHALL hold its operands stable while valid and not ready; the block does not latch operands.
REQ-020 A LAT-deep tag pipeline (valid bit + requester id per stage) SHALL advance every cycle; stage 0 loads the accepted grant.
REQ-021 An operation accepted in cycle N SHALL raise exactly one rsp_valid bit, for its requester, in cycle N+LAT, with rsp_data = sh_y.
REQ-022 Back-to-back accepts SHALL sustain one result per cycle with no bubbles and preserve issue order.
REQ-023 inflight SHALL increment on accept, decrement on result, and stay unchanged when both occur in the same cycle.
REQ-024 rsp_data SHALL be zero when no rsp_valid bit is high.

Reset
REQ-025 While rst is high: req_ready = 0, the tag valid bits are cleared, rsp_valid = 0, inflight = 0, and the round-robin pointer selects requester A first.
REQ-026 Reset mid-operation SHALL discard all in-flight tags; shifter data still in flight SHALL never produce rsp_valid.
REQ-027 The first accept SHALL be possible in the first cycle after rst falls.

Configuration
REQ-028 Macro SHIFT_SCHED_STATS_EN: when defined, adds outputs stat_a and stat_b (each 16 bits), counting accepted operations per requester. The counters wrap at 0xFFFF and clear on reset.
REQ-029 Without SHIFT_SCHED_STATS_EN, the stat ports and counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-030 Shared package shift_sched_pkg SHALL hold LAT, the requester-id encoding (A = 0, B = 1), and the direction/rotate encodings.
REQ-031 Arbitration SHALL be a sub-module, rr_arb2: a 2-input round-robin arbiter with grant output and a pointer update on accept.

Verification
REQ-032 Single request: A valid with x = 0x0000_00F0, amt = 4, dir = 1, rot = 0 in cycle 1 -> req_ready[0] = 1 in cycle 1; rsp_valid = 2'b01 with rsp_data = 0x0000_0F00 in cycle 5.
REQ-033 Contention: A and B both held valid for 4 cycles after reset -> grants A, B, A, B; results return in the same order on cycles +4, each tagged to the correct requester.
REQ-034 Rotate: B issues x = 0x8000_0001, amt = 1, dir = 0, rot = 1 -> rsp_valid = 2'b10 with rsp_data = 0xC000_0000 four cycles later.
REQ-035 Reset mid-flight: issue 3 ops, then assert rst for 1 cycle two cycles later -> no rsp_valid ever appears for those ops, and inflight = 0 after reset.
REQ-036 Streaming: A valid for 20 consecutive cycles -> 20 consecutive rsp_valid pulses and inflight saturates at 4; stat_a = 20 when SHIFT_SCHED_STATS_EN is defined.
